alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 155 +++++++++++++++
 tb/tb_alu_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq.
// The slave modport is the ALU side and the master modport is the requester side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       operator_i;
    logic [WIDTH-1:0] operand_a_i;
    logic [WIDTH-1:0] operand_b_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;
    logic             carry_o;
    logic             overflow_o;
    logic             zero_o;
    logic             negative_o;

    modport slave (
        input  valid_i, operator_i, operand_a_i, operand_b_i, ready_i,
        output ready_o, valid_o, result_o, carry_o, overflow_o, zero_o, negative_o
    );

    modport master (
        output valid_i, operator_i, operand_a_i, operand_b_i, ready_i,
        input  ready_o, valid_o, result_o, carry_o, overflow_o, zero_o, negative_o
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both the request and result sides.
// Single-cycle ops finish in one cycle; MUL is an iterative shift-add taking WIDTH cycles.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk_i,
    input  logic     rst_i,
    alu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_MUL  = 2'b01;
    localparam logic [1:0] S_OUT  = 2'b10;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_ovf;
    logic               r_zero;
    logic               r_neg;

    logic               w_ready;
    logic               w_accept;
    logic               w_consume;
    logic               w_is_mul;
    logic               w_mul_done;
    logic               w_load;
    logic [1:0]         w_state_next;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [CNT_W-1:0]   w_shamt;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_carry;
    logic               w_alu_ovf;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_carry_next;
    logic               w_ovf_next;

    assign w_ready    = (r_state == S_IDLE) || ((r_state == S_OUT) && bus.ready_i);
    assign w_accept   = bus.valid_i && w_ready;
    assign w_consume  = (r_state == S_OUT) && bus.ready_i;
    assign w_is_mul   = (bus.operator_i == OP_MUL);
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {2*WIDTH{1'b0}});

    // Single-cycle datapath works straight off the request inputs at the accepting edge.
    assign w_sum   = {1'b0, bus.operand_a_i} + {1'b0, bus.operand_b_i};
    assign w_diff  = {1'b0, bus.operand_a_i} - {1'b0, bus.operand_b_i};
    assign w_shamt = bus.operand_b_i[CNT_W-1:0];

    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_alu_ovf   = 1'b0;
        case (bus.operator_i)
            OP_ADD: begin
                w_alu_res   = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
                w_alu_ovf   = (bus.operand_a_i[WIDTH-1] == bus.operand_b_i[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != bus.operand_a_i[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res   = w_diff[WIDTH-1:0];
                w_alu_carry = w_diff[WIDTH];
                w_alu_ovf   = (bus.operand_a_i[WIDTH-1] != bus.operand_b_i[WIDTH-1]) &&
                              (w_diff[WIDTH-1] != bus.operand_a_i[WIDTH-1]);
            end
            OP_AND:  w_alu_res = bus.operand_a_i & bus.operand_b_i;
            OP_OR:   w_alu_res = bus.operand_a_i | bus.operand_b_i;
            OP_XOR:  w_alu_res = bus.operand_a_i ^ bus.operand_b_i;
            OP_SLL:  w_alu_res = bus.operand_a_i << w_shamt;
            OP_SRL:  w_alu_res = bus.operand_a_i >> w_shamt;
            default: w_alu_res = '0;
        endcase
    end

    // Accept and MUL completion are mutually exclusive because ready_o is low in MUL.
    assign w_load       = (w_accept && !w_is_mul) || w_mul_done;
    assign w_res_next   = w_mul_done ? w_acc_next[WIDTH-1:0] : w_alu_res;
    assign w_carry_next = w_mul_done ? (|w_acc_next[2*WIDTH-1:WIDTH]) : w_alu_carry;
    assign w_ovf_next   = w_mul_done ? 1'b0 : w_alu_ovf;

    always_comb begin
        w_state_next = r_state;
        if (w_accept)
            w_state_next = w_is_mul ? S_MUL : S_OUT;
        else if (w_mul_done)
            w_state_next = S_OUT;
        else if (w_consume)
            w_state_next = S_IDLE;
        else if (r_state == 2'b11)
            w_state_next = S_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept)
                r_cnt <= '0;
            else if (r_state == S_MUL)
                r_cnt <= w_mul_done ? '0 : r_cnt + CNT_W'(1);
            if (w_load) begin
                r_result <= w_res_next;
                r_carry  <= w_carry_next;
                r_ovf    <= w_ovf_next;
                r_zero   <= (w_res_next == '0);
                r_neg    <= w_res_next[WIDTH-1];
            end
        end
    end

    // Multiplier operands are captured at accept; one multiplier bit is consumed per MUL cycle.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, bus.operand_a_i};
            r_mplier <= bus.operand_b_i;
            r_acc    <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign bus.ready_o    = w_ready;
    assign bus.valid_o    = (r_state == S_OUT);
    assign bus.result_o   = r_result;
    assign bus.carry_o    = r_carry;
    assign bus.overflow_o = r_ovf;
    assign bus.zero_o     = r_zero;
    assign bus.negative_o = r_neg;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8.
// Flags are compared as {valid, carry, overflow, zero, negative}.
module tb_alu_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [4:0] fl;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    assign fl = {bus.valid_o, bus.carry_o, bus.overflow_o, bus.zero_o, bus.negative_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.operator_i  = op;
        bus.operand_a_i = a;
        bus.operand_b_i = b;
        bus.valid_i     = 1'b1;
        @(posedge clk); #1;
        bus.valid_i     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid_i = 1'b0; bus.ready_i = 1'b1;
        bus.operator_i = 3'b000; bus.operand_a_i = 8'h00; bus.operand_b_i = 8'h00;
        #3;
        checks++;
        if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready_o); end
        checks++;
        if (fl !== 5'b00000) begin errors++; $display("FAIL reset_flags got %b want 00000", fl); end
        checks++;
        if (bus.result_o !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", bus.result_o); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        issue(3'b000, 8'hFF, 8'h01);
        checks++;
        if (bus.result_o !== 8'h00) begin errors++; $display("FAIL add_result got %h want 00", bus.result_o); end
        checks++;
        if (fl !== 5'b11010) begin errors++; $display("FAIL add_flags got %b want 11010", fl); end
    endtask

    task automatic test_sub();
        issue(3'b001, 8'h80, 8'h01);
        checks++;
        if (bus.result_o !== 8'h7F) begin errors++; $display("FAIL sub_ovf_result got %h want 7f", bus.result_o); end
        checks++;
        if (fl !== 5'b10100) begin errors++; $display("FAIL sub_ovf_flags got %b want 10100", fl); end
        issue(3'b001, 8'h01, 8'h02);
        checks++;
        if (bus.result_o !== 8'hFF) begin errors++; $display("FAIL sub_borrow_result got %h want ff", bus.result_o); end
        checks++;
        if (fl !== 5'b11001) begin errors++; $display("FAIL sub_borrow_flags got %b want 11001", fl); end
    endtask

    task automatic test_logic();
        issue(3'b010, 8'hF0, 8'h3C);
        checks++;
        if ({bus.result_o, fl} !== {8'h30, 5'b10000}) begin errors++; $display("FAIL and got %h/%b want 30/10000", bus.result_o, fl); end
        issue(3'b011, 8'h0F, 8'hF0);
        checks++;
        if ({bus.result_o, fl} !== {8'hFF, 5'b10001}) begin errors++; $display("FAIL or got %h/%b want ff/10001", bus.result_o, fl); end
        issue(3'b100, 8'hAA, 8'hAA);
        checks++;
        if ({bus.result_o, fl} !== {8'h00, 5'b10010}) begin errors++; $display("FAIL xor got %h/%b want 00/10010", bus.result_o, fl); end
        issue(3'b110, 8'h80, 8'h0B);
        checks++;
        if ({bus.result_o, fl} !== {8'h10, 5'b10000}) begin errors++; $display("FAIL srl got %h/%b want 10/10000", bus.result_o, fl); end
    endtask

    task automatic test_mul();
        issue(3'b111, 8'h10, 8'h10);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({bus.ready_o, bus.valid_o} !== 2'b00) begin
                errors++; $display("FAIL mul_busy cycle %0d got rdy/vld %b%b want 00", i + 1, bus.ready_o, bus.valid_o);
            end
            // Ignored request with changed operands while the multiply is in flight.
            bus.valid_i = 1'b1; bus.operator_i = 3'b000;
            bus.operand_a_i = 8'hFF; bus.operand_b_i = 8'hFF;
            @(posedge clk); #1;
        end
        bus.valid_i = 1'b0;
        checks++;
        if ({bus.result_o, fl} !== {8'h00, 5'b11010}) begin errors++; $display("FAIL mul_ovf got %h/%b want 00/11010", bus.result_o, fl); end
        issue(3'b111, 8'h0F, 8'h0D);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL mul2_busy cycle %0d got %b want 0", i + 1, bus.ready_o); end
            @(posedge clk); #1;
        end
        checks++;
        if ({bus.result_o, fl} !== {8'hC3, 5'b10001}) begin errors++; $display("FAIL mul2 got %h/%b want c3/10001", bus.result_o, fl); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bus.ready_i = 1'b0;
        issue(3'b000, 8'h03, 8'h04);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.result_o, fl, bus.ready_o} !== {8'h07, 5'b10000, 1'b0}) begin
                errors++; $display("FAIL bp_hold cycle %0d got %h/%b/%b want 07/10000/0", i, bus.result_o, fl, bus.ready_o);
            end
            bus.valid_i = 1'b1; bus.operator_i = 3'b001; bus.operand_a_i = 8'h00; bus.operand_b_i = 8'h01;
            if (i < 3) begin @(posedge clk); #1; end
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus.valid_o, bus.ready_o} !== 2'b01) begin errors++; $display("FAIL bp_release got vld/rdy %b%b want 01", bus.valid_o, bus.ready_o); end
    endtask

    task automatic test_back_to_back();
        bus.ready_i = 1'b1;
        issue(3'b100, 8'h5A, 8'hFF);
        checks++;
        if ({bus.result_o, fl} !== {8'hA5, 5'b10001}) begin errors++; $display("FAIL b2b_xor got %h/%b want a5/10001", bus.result_o, fl); end
        issue(3'b010, 8'hC3, 8'h3C);
        checks++;
        if ({bus.result_o, fl} !== {8'h00, 5'b10010}) begin errors++; $display("FAIL b2b_and got %h/%b want 00/10010", bus.result_o, fl); end
        issue(3'b101, 8'h81, 8'h09);
        checks++;
        if ({bus.result_o, fl} !== {8'h02, 5'b10000}) begin errors++; $display("FAIL b2b_sll got %h/%b want 02/10000", bus.result_o, fl); end
        @(posedge clk); #1;
        checks++;
        if ({bus.valid_o, bus.ready_o} !== 2'b01) begin errors++; $display("FAIL b2b_idle got vld/rdy %b%b want 01", bus.valid_o, bus.ready_o); end
    endtask

    task automatic test_reset_mid_mul();
        issue(3'b111, 8'h0F, 8'h0D);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.result_o, fl, bus.ready_o} !== {8'h00, 5'b00000, 1'b1}) begin
            errors++; $display("FAIL rst_mul got %h/%b/%b want 00/00000/1", bus.result_o, fl, bus.ready_o);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(3'b000, 8'h12, 8'h34);
        checks++;
        if ({bus.result_o, fl} !== {8'h46, 5'b10000}) begin errors++; $display("FAIL rst_add got %h/%b want 46/10000", bus.result_o, fl); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
